// File: rtl/eth_pkg.sv
// Shared constants, FSM state type and byte-select helpers for the ARP frame transmitter.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE        = 8'h55;
    localparam logic [7:0]  ETH_SFD             = 8'hD5;
    localparam logic [15:0] ETHERTYPE_ARP       = 16'h0806;
    localparam logic [15:0] ARP_OPER_REQ        = 16'h0001;
    localparam logic [15:0] ARP_OPER_REPLY      = 16'h0002;
    localparam logic [31:0] CRC32_INIT          = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_POLY_REFL     = 32'hEDB88320;
    localparam int          ETH_PREAMBLE_LEN    = 8;
    localparam int          ETH_MIN_PAYLOAD_LEN = 60;
    localparam int          ETH_FCS_LEN         = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_FCS,
        ST_IFG
    } tx_state_t;

    // Byte idx of a MAC address, idx 0 being the most significant (first on the wire).
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        logic [47:0] sh;
        sh = mac << (8 * idx);
        return sh[47:40];
    endfunction

    function automatic logic [7:0] ip_byte(input logic [31:0] ip, input logic [1:0] idx);
        logic [31:0] sh;
        sh = ip << (8 * idx);
        return sh[31:24];
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Ethernet CRC32, one byte per clock, LSB-first reflected update; crc_out is the complemented FCS value.
module crc32_d8
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [31:0] crc_out
);

    logic [31:0] crc_reg;
    logic [31:0] crc_next;

    always_comb begin
        crc_next = crc_reg;
        for (int i = 0; i < 8; i++) begin
            if (crc_next[0] ^ din[i]) begin
                crc_next = (crc_next >> 1) ^ CRC32_POLY_REFL;
            end else begin
                crc_next = crc_next >> 1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_reg <= CRC32_INIT;
        end else if (clr) begin
            crc_reg <= CRC32_INIT;
        end else if (en) begin
            crc_reg <= crc_next;
        end
    end

    assign crc_out = ~crc_reg;

endmodule

// File: rtl/eth_arp_tx.sv
// GMII transmitter for Ethernet II / ARP request and reply frames with preamble, padding and FCS,
// start/busy/done handshake, inter-frame gap, PHY reset sequencing and optional periodic auto-send.
module eth_arp_tx
    import eth_pkg::*;
#(
    parameter logic [47:0] SRC_MAC        = 48'h000A3501FEC0,
    parameter logic [31:0] SRC_IP         = 32'hC0A80002,
    parameter int          IFG_CYCLES     = 12,
    parameter int          PHY_RST_CYCLES = 1000,
    parameter int          AUTO_PERIOD    = 0
) (
    input  logic        gmii_tx_clk,
    input  logic        rst_n,
    input  logic        tx_start,
    input  logic        tx_opcode,
    input  logic [47:0] tx_dst_mac,
    input  logic [31:0] tx_dst_ip,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic [7:0]  gmii_tx_data,
    output logic        phy_rst_n
);

    localparam logic [15:0] PRE_LAST  = 16'(ETH_PREAMBLE_LEN - 1);
    localparam logic [15:0] DATA_LAST = 16'(ETH_MIN_PAYLOAD_LEN - 1);
    localparam logic [15:0] FCS_LAST  = 16'(ETH_FCS_LEN - 1);
    // The IDLE cycle in which the next request is accepted is the last gap cycle,
    // so the IFG state itself lasts IFG_CYCLES-1 cycles.
    localparam logic [15:0] IFG_LAST  = 16'(IFG_CYCLES - 2);
    localparam logic [31:0] PHY_LAST  = 32'(PHY_RST_CYCLES - 1);

    tx_state_t   state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic        accept;
    logic        pending_reg, pending_next;
    logic        auto_tick;
    logic        op_reg;
    logic [47:0] mac_reg;
    logic [31:0] ip_reg;
    logic [31:0] phy_cnt_reg;
    logic        phy_rst_n_reg;
    logic        tx_en_reg, tx_busy_reg, tx_done_reg;
    logic [7:0]  tx_data_reg;
    logic [7:0]  byte_next, data_byte, fcs_byte;
    logic [15:0] oper;
    logic [5:0]  di;
    logic [31:0] crc_out;
    logic [31:0] crc_shift;

    // PHY reset: held low for PHY_RST_CYCLES clocks after rst_n release, then high for good.
    always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            phy_cnt_reg   <= '0;
            phy_rst_n_reg <= 1'b0;
        end else if (!phy_rst_n_reg) begin
            if (phy_cnt_reg == PHY_LAST) begin
                phy_rst_n_reg <= 1'b1;
            end else begin
                phy_cnt_reg <= phy_cnt_reg + 32'd1;
            end
        end
    end

    if (AUTO_PERIOD > 0) begin : g_auto
        localparam logic [31:0] AUTO_LAST = 32'(AUTO_PERIOD - 1);
        logic [31:0] auto_cnt_reg;

        assign auto_tick = phy_rst_n_reg && (auto_cnt_reg == AUTO_LAST);

        always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
            if (!rst_n) begin
                auto_cnt_reg <= '0;
            end else if (!phy_rst_n_reg || auto_tick) begin
                auto_cnt_reg <= '0;
            end else begin
                auto_cnt_reg <= auto_cnt_reg + 32'd1;
            end
        end
    end else begin : g_no_auto
        assign auto_tick = 1'b0;
    end

    assign pending_next = (pending_reg && !accept) || auto_tick;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (phy_rst_n_reg && (tx_start || pending_reg)) begin
                    accept     = 1'b1;
                    state_next = ST_PREAMBLE;
                    cnt_next   = '0;
                end
            end
            ST_PREAMBLE: begin
                if (cnt_reg == PRE_LAST) begin
                    state_next = ST_DATA;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt_reg == DATA_LAST) begin
                    state_next = ST_FCS;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            ST_FCS: begin
                if (cnt_reg == FCS_LAST) begin
                    state_next = ST_IFG;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            ST_IFG: begin
                if (cnt_reg == IFG_LAST) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Field mux: payload byte di of the frame that will be on the wire next cycle.
    assign di   = cnt_next[5:0];
    assign oper = op_reg ? ARP_OPER_REPLY : ARP_OPER_REQ;

    always_comb begin
        data_byte = 8'h00;
        if (di < 6'd6) begin
            data_byte = op_reg ? mac_byte(mac_reg, di[2:0]) : 8'hFF;
        end else if (di < 6'd12) begin
            data_byte = mac_byte(SRC_MAC, 3'(di - 6'd6));
        end else if (di == 6'd12) begin
            data_byte = ETHERTYPE_ARP[15:8];
        end else if (di == 6'd13) begin
            data_byte = ETHERTYPE_ARP[7:0];
        end else if (di == 6'd15) begin
            data_byte = 8'h01;
        end else if (di == 6'd16) begin
            data_byte = 8'h08;
        end else if (di == 6'd18) begin
            data_byte = 8'h06;
        end else if (di == 6'd19) begin
            data_byte = 8'h04;
        end else if (di == 6'd20) begin
            data_byte = oper[15:8];
        end else if (di == 6'd21) begin
            data_byte = oper[7:0];
        end else if (di >= 6'd22 && di < 6'd28) begin
            data_byte = mac_byte(SRC_MAC, 3'(di - 6'd22));
        end else if (di >= 6'd28 && di < 6'd32) begin
            data_byte = ip_byte(SRC_IP, 2'(di - 6'd28));
        end else if (di >= 6'd32 && di < 6'd38) begin
            data_byte = op_reg ? mac_byte(mac_reg, 3'(di - 6'd32)) : 8'h00;
        end else if (di >= 6'd38 && di < 6'd42) begin
            data_byte = ip_byte(ip_reg, 2'(di - 6'd38));
        end
    end

    assign crc_shift = crc_out >> (8 * cnt_next[1:0]);
    assign fcs_byte  = crc_shift[7:0];

    always_comb begin
        byte_next = 8'h00;
        case (state_next)
            ST_PREAMBLE: byte_next = (cnt_next == PRE_LAST) ? ETH_SFD : ETH_PREAMBLE;
            ST_DATA:     byte_next = data_byte;
            ST_FCS:      byte_next = fcs_byte;
            default:     byte_next = 8'h00;
        endcase
    end

    // The CRC absorbs each payload byte at the same edge that registers it onto the bus,
    // so the complete FCS is ready for the first FCS byte.
    crc32_d8 u_crc (
        .clk     (gmii_tx_clk),
        .rst_n   (rst_n),
        .clr     (state_next == ST_PREAMBLE),
        .en      (state_next == ST_DATA),
        .din     (byte_next),
        .crc_out (crc_out)
    );

    always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            pending_reg <= 1'b0;
            op_reg      <= 1'b0;
            mac_reg     <= '0;
            ip_reg      <= '0;
            tx_en_reg   <= 1'b0;
            tx_data_reg <= 8'h00;
            tx_busy_reg <= 1'b0;
            tx_done_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            pending_reg <= pending_next;
            tx_en_reg   <= (state_next == ST_PREAMBLE) || (state_next == ST_DATA) ||
                           (state_next == ST_FCS);
            tx_data_reg <= byte_next;
            tx_busy_reg <= (state_next != ST_IDLE);
            tx_done_reg <= (state_reg == ST_FCS) && (state_next == ST_IFG);
            if (accept) begin
                // An auto-send request (no tx_start) is always an ARP request.
                op_reg  <= tx_start ? tx_opcode : 1'b0;
                mac_reg <= tx_dst_mac;
                ip_reg  <= tx_dst_ip;
            end
        end
    end

    assign gmii_tx_en   = tx_en_reg;
    assign gmii_tx_er   = 1'b0;
    assign gmii_tx_data = tx_data_reg;
    assign tx_busy      = tx_busy_reg;
    assign tx_done      = tx_done_reg;
    assign phy_rst_n    = phy_rst_n_reg;

endmodule

// File: tb/tb_eth_arp_tx.sv
// Directed bench for eth_arp_tx (manual and auto-send instances) and the crc32_d8 unit.
module tb_eth_arp_tx;

    localparam logic [47:0] MY_MAC = 48'h000A3501FEC0;
    localparam logic [31:0] MY_IP  = 32'hC0A80002;
    localparam int IFG_M = 16;
    localparam int IFG_A = 12;
    localparam int WIN   = 100;

    logic clk = 1'b0;
    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n, tx_start, tx_opcode;
    logic [47:0] tx_dst_mac;
    logic [31:0] tx_dst_ip;
    logic        tx_busy, tx_done, gmii_tx_en, gmii_tx_er, phy_rst_n;
    logic [7:0]  gmii_tx_data;

    logic        a_rst_n, a_start, a_op;
    logic [47:0] a_mac;
    logic [31:0] a_ip;
    logic        a_busy, a_done, a_en, a_er, a_phy;
    logic [7:0]  a_data;

    logic        c_clr, c_en;
    logic [7:0]  c_din;
    logic [31:0] c_out;

    eth_arp_tx #(.IFG_CYCLES(IFG_M), .PHY_RST_CYCLES(10), .AUTO_PERIOD(0)) dut (
        .gmii_tx_clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_opcode(tx_opcode),
        .tx_dst_mac(tx_dst_mac), .tx_dst_ip(tx_dst_ip), .tx_busy(tx_busy), .tx_done(tx_done),
        .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er), .gmii_tx_data(gmii_tx_data),
        .phy_rst_n(phy_rst_n)
    );

    eth_arp_tx #(.IFG_CYCLES(IFG_A), .PHY_RST_CYCLES(10), .AUTO_PERIOD(500)) dut_auto (
        .gmii_tx_clk(clk), .rst_n(a_rst_n), .tx_start(a_start), .tx_opcode(a_op),
        .tx_dst_mac(a_mac), .tx_dst_ip(a_ip), .tx_busy(a_busy), .tx_done(a_done),
        .gmii_tx_en(a_en), .gmii_tx_er(a_er), .gmii_tx_data(a_data), .phy_rst_n(a_phy)
    );

    crc32_d8 u_crc (
        .clk(clk), .rst_n(rst_n), .clr(c_clr), .en(c_en), .din(c_din), .crc_out(c_out)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    logic [7:0] exp_f [0:71];

    // Reference frame: 480-bit payload built as one concatenation, CRC by bitwise software loop.
    task automatic build_exp(input logic op, input logic [47:0] mac, input logic [31:0] ip);
        logic [479:0] pdu;
        logic [47:0]  dst, tha;
        logic [31:0]  c;
        dst = op ? mac : 48'hFFFF_FFFF_FFFF;
        tha = op ? mac : 48'h0;
        pdu = {dst, MY_MAC, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
               (op ? 16'h0002 : 16'h0001), MY_MAC, MY_IP, tha, ip, 144'h0};
        for (int i = 0; i < 7; i++) exp_f[i] = 8'h55;
        exp_f[7] = 8'hD5;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 60; i++) begin
            exp_f[8+i] = pdu[479-8*i -: 8];
            c = c ^ {24'h0, exp_f[8+i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) exp_f[68+k] = c[8*k +: 8];
    endtask

    logic       cap_en   [0:WIN-1];
    logic [7:0] cap_d    [0:WIN-1];
    logic       cap_done [0:WIN-1];
    logic       cap_busy [0:WIN-1];

    // Record WIN cycles of one instance; now=1 takes the current sample as index 0.
    task automatic record(input bit sel, input bit now);
        for (int i = 0; i < WIN; i++) begin
            if (i > 0 || !now) @(negedge clk);
            cap_en[i]   = sel ? a_en   : gmii_tx_en;
            cap_d[i]    = sel ? a_data : gmii_tx_data;
            cap_done[i] = sel ? a_done : tx_done;
            cap_busy[i] = sel ? a_busy : tx_busy;
            check("gmii_tx_er", 64'(sel ? a_er : gmii_tx_er), 64'(0));
            if (i == 0 && !sel) begin
                // Inputs change after acceptance; the frame must use the latched values.
                tx_start   = 1'b0;
                tx_opcode  = ~tx_opcode;
                tx_dst_mac = ~tx_dst_mac;
                tx_dst_ip  = ~tx_dst_ip;
            end
        end
    endtask

    task automatic check_frame(input string tag, input int ifg, input logic [47:0] e_dst,
                               input logic [15:0] e_oper, input logic [47:0] e_tha,
                               input logic [31:0] e_tpa);
        int run, bad, first_bad, dones, done_at, busy_fall, dirty;
        logic [47:0] dst, tha;
        logic [31:0] tpa, fcs_got, fcs_exp;
        logic [15:0] oper;
        run = 0;
        while (run < WIN && cap_en[run]) run++;
        check({tag, " en_run"}, 64'(run), 64'(72));
        bad = 0; first_bad = -1;
        for (int i = 0; i < 72; i++) begin
            if (cap_d[i] !== exp_f[i]) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        check($sformatf("%s bytes(first_bad=%0d)", tag, first_bad), 64'(bad), 64'(0));
        dst = '0; tha = '0; tpa = '0;
        for (int k = 0; k < 6; k++) dst = {dst[39:0], cap_d[8+k]};
        for (int k = 0; k < 6; k++) tha = {tha[39:0], cap_d[40+k]};
        for (int k = 0; k < 4; k++) tpa = {tpa[23:0], cap_d[46+k]};
        oper = {cap_d[28], cap_d[29]};
        check({tag, " dst_mac"}, 64'(dst), 64'(e_dst));
        check({tag, " oper"}, 64'(oper), 64'(e_oper));
        check({tag, " tha"}, 64'(tha), 64'(e_tha));
        check({tag, " tpa"}, 64'(tpa), 64'(e_tpa));
        fcs_got = {cap_d[71], cap_d[70], cap_d[69], cap_d[68]};
        fcs_exp = {exp_f[71], exp_f[70], exp_f[69], exp_f[68]};
        check({tag, " fcs"}, 64'(fcs_got), 64'(fcs_exp));
        dones = 0; done_at = -1; busy_fall = -1; dirty = 0;
        for (int i = 0; i < WIN; i++) begin
            if (cap_done[i]) begin
                dones++;
                done_at = i;
            end
            if (!cap_busy[i] && busy_fall < 0) busy_fall = i;
            if (!cap_en[i] && cap_d[i] != 8'h00) dirty++;
        end
        check({tag, " done_count"}, 64'(dones), 64'(1));
        check({tag, " done_cycle"}, 64'(done_at), 64'(72));
        check({tag, " busy_fall"}, 64'(busy_fall), 64'(71 + ifg));
        check({tag, " data_idle_zero"}, 64'(dirty), 64'(0));
        $display("frame %s: en_run=%0d fcs=%08h done_at=%0d busy_fall=%0d",
                 tag, run, fcs_got, done_at, busy_fall);
    endtask

    // Wait for a 0->1 transition of the auto instance's gmii_tx_en, bounded.
    task automatic wait_auto_rise(output int t, output bit ok);
        ok = 1'b0; t = 0;
        for (int i = 0; i < 700 && a_en; i++) @(negedge clk);
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (a_en) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
        end
        check("auto en rise within bound", 64'(ok), 64'(1));
    endtask

    typedef struct {
        logic        op;
        logic [47:0] mac;
        logic [31:0] ip;
        logic [47:0] e_dst;
        logic [15:0] e_oper;
        logic [47:0] e_tha;
    } vec_t;

    typedef struct {
        string       s;
        logic [31:0] crc;
    } crc_vec_t;

    vec_t     vecs [4];
    crc_vec_t cvecs [4];

    initial begin
        int phy_at, early, rises, seg, seg_len[4], t1, t2, t3;
        bit ok, prev;
        logic en_s;

        vecs[0] = '{1'b0, 48'h112233445566, 32'hC0A80003, 48'hFFFFFFFFFFFF, 16'h0001, 48'h0};
        vecs[1] = '{1'b1, 48'h112233445566, 32'hC0A80003, 48'h112233445566, 16'h0002, 48'h112233445566};
        vecs[2] = '{1'b1, 48'hDEADBEEF0001, 32'h0A000001, 48'hDEADBEEF0001, 16'h0002, 48'hDEADBEEF0001};
        vecs[3] = '{1'b0, 48'h000000000000, 32'hFFFFFFFF, 48'hFFFFFFFFFFFF, 16'h0001, 48'h0};
        cvecs[0] = '{"123456789", 32'hCBF43926};
        cvecs[1] = '{"a", 32'hE8B7BE43};
        cvecs[2] = '{"abc", 32'h352441C2};
        cvecs[3] = '{"", 32'h00000000};

        rst_n = 1'b0; tx_start = 1'b0; tx_opcode = 1'b0; tx_dst_mac = '0; tx_dst_ip = '0;
        a_rst_n = 1'b0; a_start = 1'b0; a_op = 1'b0; a_mac = '0; a_ip = 32'hC0A80063;
        c_clr = 1'b0; c_en = 1'b0; c_din = 8'h00;

        #100;
        check("reset gmii_tx_en", 64'(gmii_tx_en), 64'(0));
        check("reset gmii_tx_er", 64'(gmii_tx_er), 64'(0));
        check("reset gmii_tx_data", 64'(gmii_tx_data), 64'(0));
        check("reset tx_busy", 64'(tx_busy), 64'(0));
        check("reset tx_done", 64'(tx_done), 64'(0));
        check("reset phy_rst_n", 64'(phy_rst_n), 64'(0));
        #101;
        rst_n = 1'b1; a_rst_n = 1'b1;

        // PHY sequencing, with a tx_start pulse while the PHY is still in reset.
        phy_at = -1; early = 0;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (phy_rst_n && phy_at < 0) phy_at = j;
            if (gmii_tx_en || tx_busy || gmii_tx_data != 8'h00) early++;
            tx_start = (j == 3 || j == 4);
        end
        check("phy_rst_n release cycle", 64'(phy_at), 64'(10));
        check("no activity before/after ignored start", 64'(early), 64'(0));
        $display("phy: phy_rst_n high after %0d clocks", phy_at);

        // Table-driven single frames.
        foreach (vecs[v]) begin
            build_exp(vecs[v].op, vecs[v].mac, vecs[v].ip);
            @(negedge clk);
            tx_opcode = vecs[v].op; tx_dst_mac = vecs[v].mac; tx_dst_ip = vecs[v].ip;
            tx_start = 1'b1;
            record(1'b0, 1'b0);
            check_frame($sformatf("vec%0d", v), IFG_M, vecs[v].e_dst, vecs[v].e_oper,
                        vecs[v].e_tha, vecs[v].ip);
        end

        // Back-to-back: tx_start held high.
        @(negedge clk);
        tx_opcode = 1'b0; tx_dst_ip = 32'hC0A80005; tx_start = 1'b1;
        prev = 1'b0; rises = 0; seg = 0;
        foreach (seg_len[k]) seg_len[k] = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            en_s = gmii_tx_en;
            if (i > 0 && en_s != prev && seg < 3) seg++;
            if (seg < 4) seg_len[seg]++;
            if (en_s && !prev) rises++;
            prev = en_s;
        end
        tx_start = 1'b0;
        check("b2b first frame length", 64'(seg_len[0]), 64'(72));
        check("b2b gap length", 64'(seg_len[1]), 64'(IFG_M));
        check("b2b second frame length", 64'(seg_len[2]), 64'(72));
        check("b2b frames started in 200 cycles", 64'(rises), 64'(3));
        $display("b2b: run=%0d gap=%0d run=%0d starts=%0d", seg_len[0], seg_len[1], seg_len[2], rises);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!tx_busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("b2b drains to idle", 64'(ok), 64'(1));

        // Extra tx_start pulses mid-frame and during IFG are dropped.
        @(negedge clk);
        tx_start = 1'b1;
        prev = 1'b0; rises = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (gmii_tx_en && !prev) rises++;
            prev = gmii_tx_en;
            tx_start = (i == 30 || i == 80);
        end
        check("mid-frame starts dropped", 64'(rises), 64'(1));
        $display("drop: frames started=%0d", rises);

        // crc32_d8 unit vectors.
        foreach (cvecs[v]) begin
            @(negedge clk);
            c_clr = 1'b1;
            @(negedge clk);
            c_clr = 1'b0;
            for (int i = 0; i < cvecs[v].s.len(); i++) begin
                c_en = 1'b1;
                c_din = cvecs[v].s[i];
                @(negedge clk);
            end
            c_en = 1'b0;
            check($sformatf("crc32 \"%s\"", cvecs[v].s), 64'(c_out), 64'(cvecs[v].crc));
            $display("crc \"%s\" -> %08h", cvecs[v].s, c_out);
        end

        // Auto-send period and frame content.
        build_exp(1'b0, 48'h0, a_ip);
        wait_auto_rise(t1, ok);
        wait_auto_rise(t2, ok);
        record(1'b1, 1'b1);
        check("auto period", 64'(t2 - t1), 64'(500));
        check_frame("auto", IFG_A, 48'hFFFFFFFFFFFF, 16'h0001, 48'h0, a_ip);

        // Reset at DATA byte 20 of the next auto frame.
        wait_auto_rise(t3, ok);
        for (int i = 1; i <= 28; i++) @(negedge clk);
        check("auto mid-frame en before reset", 64'(a_en), 64'(1));
        check("auto mid-frame byte 20", 64'(a_data), 64'(exp_f[28]));
        a_rst_n = 1'b0;
        #1;
        check("async reset gmii_tx_en", 64'(a_en), 64'(0));
        check("async reset gmii_tx_data", 64'(a_data), 64'(0));
        check("async reset phy_rst_n", 64'(a_phy), 64'(0));
        check("async reset tx_busy", 64'(a_busy), 64'(0));
        #26;
        a_rst_n = 1'b1;
        phy_at = -1;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (a_phy && phy_at < 0) phy_at = j;
        end
        check("auto phy_rst_n rerun", 64'(phy_at), 64'(10));
        wait_auto_rise(t1, ok);
        record(1'b1, 1'b1);
        check_frame("auto_after_reset", IFG_A, 48'hFFFFFFFFFFFF, 16'h0001, 48'h0, a_ip);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
